moving_avg_filter: RTL and testbench

Parametrised boxcar (moving-average) filter over the last DEPTH = 2**LOG2_DEPTH accepted samples of an unsigned stream. It keeps a circular sample buffer and an incremental running sum, and outputs both the full window sum and the averaged value. Truncating or round-half-up division is selectable per sample. It sits in the sample-processing path between a sensor/ADC front end and downstream decision logic; valid-qualified in, valid-qualified out.

---
 rtl/mavg_pkg.sv | 38 +++
 rtl/sample_ring.sv | 66 ++++++
 rtl/moving_avg_filter.sv | 136 +++++++++++++
 tb/tb_moving_avg_filter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mavg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mavg_pkg
// Description : Shared definitions for the moving-average filter: window
//               size helpers, rounding-mode encoding and the legal range
//               of LOG2_DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
package mavg_pkg;

  // Legal window range: DEPTH = 2 .. 256
  localparam int LOG2_DEPTH_MIN = 1;
  localparam int LOG2_DEPTH_MAX = 8;

  // Windows at or above this size are built as an un-reset memory array
  // so they can map onto distributed RAM instead of flops.
  localparam int RING_RAM_MIN_LOG2 = 5;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } rnd_mode_e;

  function automatic int calc_depth(input int log2_depth);
    return 1 << log2_depth;
  endfunction

  // The window sum of DEPTH samples of DATA_W bits always fits here
  function automatic int calc_sum_w(input int data_w, input int log2_depth);
    return data_w + log2_depth;
  endfunction

  function automatic bit log2_depth_ok(input int log2_depth);
    return (log2_depth >= LOG2_DEPTH_MIN) && (log2_depth <= LOG2_DEPTH_MAX);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sample_ring.sv
`default_nettype none
// ============================================================================
// Module      : sample_ring
// Description : DEPTH x DATA_W circular sample buffer. One write per accepted
//               sample; the entry under the write pointer (the oldest sample
//               once the window is full) is read combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_ring
  import mavg_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int LOG2_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] oldest_o
);

  localparam int DEPTH = calc_depth(LOG2_DEPTH);

  logic [LOG2_DEPTH-1:0] wr_ptr_q;
  logic [LOG2_DEPTH-1:0] wr_ptr_d;
  logic [DATA_W-1:0]     mem_q [DEPTH];

  // Natural power-of-two wrap of the write pointer
  assign wr_ptr_d = wr_ptr_q + LOG2_DEPTH'(1);

  // Write pointer: restarts on reset or flush, advances per written sample
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      wr_ptr_q <= '0;
    end else if (wr_en_i) begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  if (LOG2_DEPTH < RING_RAM_MIN_LOG2) begin : g_regs
    // Small window: flop array, zeroed on reset and flush
    always_ff @(posedge clk) begin
      if (rst || clear_i) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[i] <= '0;
        end
      end else if (wr_en_i) begin
        mem_q[wr_ptr_q] <= wr_data_i;
      end
    end
  end else begin : g_ram
    // Large window: plain memory array; stale entries after a reset or
    // flush are never evicted into the sum because the parent masks the
    // read value until the window has been refilled.
    always_ff @(posedge clk) begin
      if (wr_en_i && !rst && !clear_i) begin
        mem_q[wr_ptr_q] <= wr_data_i;
      end
    end
  end

  assign oldest_o = mem_q[wr_ptr_q];

endmodule
`default_nettype wire

// File: rtl/moving_avg_filter.sv
`default_nettype none
// ============================================================================
// Module      : moving_avg_filter
// Description : Boxcar average over the last 2**LOG2_DEPTH accepted unsigned
//               samples. Running sum is maintained incrementally (add the
//               new sample, subtract the evicted one). Outputs the window
//               sum and the truncated or round-half-up average one cycle
//               after each accepted sample.
// Revision    : 1.0 - initial release
// ============================================================================
module moving_avg_filter
  import mavg_pkg::*;
#(
  parameter  int DATA_W     = 4,
  parameter  int LOG2_DEPTH = 2,
  localparam int SUM_W      = calc_sum_w(DATA_W, LOG2_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              x_is_valid,
  input  logic [DATA_W-1:0] x,
  input  logic              round_en,
  output logic [DATA_W-1:0] y,
  output logic [SUM_W-1:0]  y_sum,
  output logic              y_is_valid
);

  localparam int                 DEPTH     = calc_depth(LOG2_DEPTH);
  localparam int                 FILL_W    = LOG2_DEPTH + 1;
  localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(DEPTH);
  localparam logic [SUM_W:0]     RND_HALF  = (SUM_W + 1)'(DEPTH / 2);

  if (!log2_depth_ok(LOG2_DEPTH)) begin : g_bad_log2_depth
    $error("moving_avg_filter: LOG2_DEPTH=%0d outside %0d..%0d",
           LOG2_DEPTH, LOG2_DEPTH_MIN, LOG2_DEPTH_MAX);
  end

  logic [SUM_W-1:0]  sum_q,   sum_d;
  logic [FILL_W-1:0] fill_q,  fill_d;
  logic [DATA_W-1:0] y_q,     y_d;
  logic [SUM_W-1:0]  y_sum_q, y_sum_d;
  logic              y_vld_q, y_vld_d;

  logic [DATA_W-1:0] w_oldest;
  logic [DATA_W-1:0] w_evict;
  logic              w_full;
  logic [SUM_W:0]    w_sum_wide;
  logic [SUM_W-1:0]  w_sum_next;
  logic [FILL_W-1:0] w_fill_next;
  logic [SUM_W:0]    w_rnd_wide;
  logic [DATA_W-1:0] w_avg_trunc;
  logic [DATA_W-1:0] w_avg_round;
  logic [DATA_W-1:0] w_avg;
  rnd_mode_e         w_mode;
  logic              w_unused;

  sample_ring #(
    .DATA_W     (DATA_W),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ring (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (clear),
    .wr_en_i   (x_is_valid),
    .wr_data_i (x),
    .oldest_o  (w_oldest)
  );

  // While the window is still filling nothing is evicted
  assign w_full  = (fill_q == FILL_FULL);
  assign w_evict = w_full ? w_oldest : '0;

  // One guard bit keeps the intermediate add/subtract exact
  assign w_sum_wide = {1'b0, sum_q} + (SUM_W + 1)'(x) - (SUM_W + 1)'(w_evict);
  assign w_sum_next = w_sum_wide[SUM_W-1:0];

  assign w_fill_next = w_full ? fill_q : fill_q + FILL_W'(1);

  // Division by DEPTH is a shift; rounding adds half an LSB first
  assign w_rnd_wide  = {1'b0, w_sum_next} + RND_HALF;
  assign w_avg_trunc = w_sum_next[SUM_W-1:LOG2_DEPTH];
  assign w_avg_round = w_rnd_wide[SUM_W-1:LOG2_DEPTH];
  assign w_mode      = rnd_mode_e'(round_en);
  assign w_avg       = (w_mode == RND_HALF_UP) ? w_avg_round : w_avg_trunc;

  assign w_unused = ^{w_sum_wide[SUM_W], w_rnd_wide[SUM_W], w_rnd_wide[LOG2_DEPTH-1:0]};

  // Next-state: flush beats a sample; otherwise update on each accepted sample
  always_comb begin
    sum_d   = sum_q;
    fill_d  = fill_q;
    y_d     = y_q;
    y_sum_d = y_sum_q;
    y_vld_d = 1'b0;
    if (clear) begin
      sum_d  = '0;
      fill_d = '0;
    end else if (x_is_valid) begin
      sum_d   = w_sum_next;
      fill_d  = w_fill_next;
      y_d     = w_avg;
      y_sum_d = w_sum_next;
      y_vld_d = (w_fill_next == FILL_FULL);
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      fill_q  <= '0;
      y_q     <= '0;
      y_sum_q <= '0;
      y_vld_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      fill_q  <= fill_d;
      y_q     <= y_d;
      y_sum_q <= y_sum_d;
      y_vld_q <= y_vld_d;
    end
  end

  // The rounded quotient can never exceed the DATA_W range
  always_comb begin
    assert (w_rnd_wide[SUM_W] == 1'b0)
      else $error("moving_avg_filter: rounded average exceeds DATA_W range");
  end

  assign y          = y_q;
  assign y_sum      = y_sum_q;
  assign y_is_valid = y_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_moving_avg_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_moving_avg_filter
// Description : Self-checking bench. Instance A (DATA_W=4, LOG2_DEPTH=2) is
//               driven from a vector table of directed scenarios; instance B
//               (DATA_W=8, LOG2_DEPTH=3) takes a random gapped stream checked
//               against a queue-based window model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_moving_avg_filter;

  typedef struct {
    bit clr;
    bit vld;
    int x;
    bit rnd;
    int e_sum;
    int e_y;
    bit e_v;
  } vec_t;

  localparam int B_DEPTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A signals
  logic       rst_a, a_clr, a_vld, a_rnd;
  logic [3:0] a_x, a_y;
  logic [5:0] a_sum;
  logic       a_yv;

  // Instance B signals
  logic        rst_b, b_clr, b_vld, b_rnd;
  logic [7:0]  b_x, b_y;
  logic [10:0] b_sum;
  logic        b_yv;

  int checks = 0;
  int errors = 0;

  // Window model for instance B
  int qb[$];
  int m_sum = 0;
  int m_y   = 0;
  bit m_v   = 1'b0;

  vec_t tbl[$];

  moving_avg_filter #(.DATA_W(4), .LOG2_DEPTH(2)) dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .clear      (a_clr),
    .x_is_valid (a_vld),
    .x          (a_x),
    .round_en   (a_rnd),
    .y          (a_y),
    .y_sum      (a_sum),
    .y_is_valid (a_yv)
  );

  moving_avg_filter #(.DATA_W(8), .LOG2_DEPTH(3)) dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .clear      (b_clr),
    .x_is_valid (b_vld),
    .x          (b_x),
    .round_en   (b_rnd),
    .y          (b_y),
    .y_sum      (b_sum),
    .y_is_valid (b_yv)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(input bit c, input bit vl, input int x, input bit r,
                             input int s, input int y, input bit ev);
    vec_t t;
    t.clr = c; t.vld = vl; t.x = x; t.rnd = r;
    t.e_sum = s; t.e_y = y; t.e_v = ev;
    return t;
  endfunction

  // One cycle on instance B: update the model, clock, compare
  task automatic b_cycle(input bit r, input bit c, input bit vl, input int x, input bit rn);
    int s;
    if (r) begin
      qb.delete();
      m_sum = 0; m_y = 0; m_v = 1'b0;
    end else if (c) begin
      qb.delete();
      m_v = 1'b0;
    end else if (vl) begin
      qb.push_back(x);
      if (qb.size() > B_DEPTH) void'(qb.pop_front());
      s = 0;
      foreach (qb[i]) s += qb[i];
      m_sum = s;
      m_y   = rn ? (s + B_DEPTH / 2) / B_DEPTH : s / B_DEPTH;
      m_v   = (qb.size() == B_DEPTH);
    end else begin
      m_v = 1'b0;
    end
    rst_b = r; b_clr = c; b_vld = vl; b_x = 8'(x); b_rnd = rn;
    @(posedge clk);
    #1;
    chk("b_sum", int'(b_sum), m_sum);
    chk("b_y",   int'(b_y),   m_y);
    chk("b_vld", int'(b_yv),  int'(m_v));
  endtask

  initial begin
    // Scenario 1: 3,4,5,6,7,8 truncated
    tbl.push_back(v(0,1,3,0, 3,0,0));
    tbl.push_back(v(0,1,4,0, 7,1,0));
    tbl.push_back(v(0,1,5,0,12,3,0));
    tbl.push_back(v(0,1,6,0,18,4,1));
    tbl.push_back(v(0,1,7,0,22,5,1));
    tbl.push_back(v(0,1,8,0,26,6,1));
    tbl.push_back(v(1,0,0,0,26,6,0));
    // Scenario 2: same stream, rounded
    tbl.push_back(v(0,1,3,1, 3,1,0));
    tbl.push_back(v(0,1,4,1, 7,2,0));
    tbl.push_back(v(0,1,5,1,12,3,0));
    tbl.push_back(v(0,1,6,1,18,5,1));
    tbl.push_back(v(0,1,7,1,22,6,1));
    tbl.push_back(v(0,1,8,1,26,7,1));
    tbl.push_back(v(1,0,0,0,26,7,0));
    // Max values truncated, then a 0
    tbl.push_back(v(0,1,15,0,15, 3,0));
    tbl.push_back(v(0,1,15,0,30, 7,0));
    tbl.push_back(v(0,1,15,0,45,11,0));
    tbl.push_back(v(0,1,15,0,60,15,1));
    tbl.push_back(v(0,1, 0,0,45,11,1));
    tbl.push_back(v(1,0, 0,0,45,11,0));
    // Max values rounded, then a 0
    tbl.push_back(v(0,1,15,1,15, 4,0));
    tbl.push_back(v(0,1,15,1,30, 8,0));
    tbl.push_back(v(0,1,15,1,45,11,0));
    tbl.push_back(v(0,1,15,1,60,15,1));
    tbl.push_back(v(0,1, 0,1,45,11,1));
    tbl.push_back(v(1,0, 0,0,45,11,0));
    // Gapped valid: two idle cycles between samples
    tbl.push_back(v(0,1,3,0, 3,0,0));
    tbl.push_back(v(0,0,9,0, 3,0,0));
    tbl.push_back(v(0,0,9,0, 3,0,0));
    tbl.push_back(v(0,1,4,0, 7,1,0));
    tbl.push_back(v(0,0,9,0, 7,1,0));
    tbl.push_back(v(0,0,9,0, 7,1,0));
    tbl.push_back(v(0,1,5,0,12,3,0));
    tbl.push_back(v(0,0,9,0,12,3,0));
    tbl.push_back(v(0,0,9,0,12,3,0));
    tbl.push_back(v(0,1,6,0,18,4,1));
    tbl.push_back(v(0,0,9,0,18,4,0));
    tbl.push_back(v(0,0,9,0,18,4,0));
    tbl.push_back(v(1,0,0,0,18,4,0));
    // Mid-stream clear (with a sample on the clear cycle), then 1,1,1,1
    tbl.push_back(v(0,1,3,0, 3,0,0));
    tbl.push_back(v(0,1,4,0, 7,1,0));
    tbl.push_back(v(0,1,5,0,12,3,0));
    tbl.push_back(v(0,1,6,0,18,4,1));
    tbl.push_back(v(0,1,7,0,22,5,1));
    tbl.push_back(v(1,1,9,0,22,5,0));
    tbl.push_back(v(0,1,1,0, 1,0,0));
    tbl.push_back(v(0,1,1,0, 2,0,0));
    tbl.push_back(v(0,1,1,0, 3,0,0));
    tbl.push_back(v(0,1,1,0, 4,1,1));

    rst_a = 1'b1; a_clr = 1'b0; a_vld = 1'b0; a_x = '0; a_rnd = 1'b0;
    rst_b = 1'b1; b_clr = 1'b0; b_vld = 1'b0; b_x = '0; b_rnd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_a_sum", int'(a_sum), 0);
    chk("rst_a_y",   int'(a_y),   0);
    chk("rst_a_vld", int'(a_yv),  0);
    chk("rst_b_sum", int'(b_sum), 0);
    chk("rst_b_y",   int'(b_y),   0);
    chk("rst_b_vld", int'(b_yv),  0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Directed table on instance A
    for (int i = 0; i < tbl.size(); i++) begin
      a_clr = tbl[i].clr; a_vld = tbl[i].vld; a_x = 4'(tbl[i].x); a_rnd = tbl[i].rnd;
      @(posedge clk);
      #1;
      chk($sformatf("a_sum[%0d]", i), int'(a_sum), tbl[i].e_sum);
      chk($sformatf("a_y[%0d]",   i), int'(a_y),   tbl[i].e_y);
      chk($sformatf("a_vld[%0d]", i), int'(a_yv),  int'(tbl[i].e_v));
    end
    a_clr = 1'b0; a_vld = 1'b0;

    // Random gapped stream on instance B with a reset at sample 100
    for (int smp = 0; smp < 200; smp++) begin
      int gaps;
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        b_cycle(1'b0, 1'b0, 1'b0, $urandom_range(0, 255), 1'($urandom_range(0, 1)));
      end
      if (smp == 100) begin
        // Reset beats a simultaneous sample; outputs must read 0 afterwards
        b_cycle(1'b1, 1'b0, 1'b1, $urandom_range(0, 255), 1'b0);
      end else if ($urandom_range(0, 39) == 0) begin
        b_cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 255), 1'b0);
      end
      b_cycle(1'b0, 1'b0, 1'b1, $urandom_range(0, 255), 1'($urandom_range(0, 1)));
    end
    // Full-scale samples exercise the rounding ceiling
    for (int k = 0; k < 10; k++) begin
      b_cycle(1'b0, 1'b0, 1'b1, 255, 1'b1);
    end
    b_cycle(1'b0, 1'b0, 1'b0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
